// File: rtl/riscv_32i_defs_pkg.sv
// Shared definitions for the 32-bit core: machine word width and the
// LUT RAM clear-sequencer state type.
package riscv_32i_defs_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    LUT_IDLE  = 1'b0,
    LUT_CLEAR = 1'b1
  } lut_clr_state_t;

endpackage : riscv_32i_defs_pkg

// File: rtl/lut_ram_rd_port.sv
// One read port of lut_ram_mp: range check, busy/range zero-force, and an
// optional output register with write-first merge of a same-edge write.
module lut_ram_rd_port
  import riscv_32i_defs_pkg::*;
#(
  parameter int LUT_WIDTH     = XLEN,
  parameter int LUT_DEPTH     = 256,
  parameter int RD_REGISTERED = 0,
  localparam int ADDR_W       = $clog2(LUT_DEPTH),
  localparam int NUM_BYTES    = LUT_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_busy,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  input  logic [LUT_WIDTH-1:0] i_mem_word,
  input  logic                 i_wr_commit,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [NUM_BYTES-1:0] i_wr_strb,
  input  logic [LUT_WIDTH-1:0] i_wr_data,
  output logic [LUT_WIDTH-1:0] o_rd_data
);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(LUT_DEPTH);

  logic                 w_in_range;
  logic                 w_hit;
  logic [LUT_WIDTH-1:0] w_merged;

  assign w_in_range = ({1'b0, i_rd_addr} < DEPTH_EXT);
  assign w_hit      = i_wr_commit && (i_wr_addr == i_rd_addr);

  // Word as it will look after this edge: strobed bytes of a colliding write win.
  always_comb begin
    w_merged = i_mem_word;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (w_hit && i_wr_strb[b]) begin
        w_merged[b*8 +: 8] = i_wr_data[b*8 +: 8];
      end else begin
        w_merged[b*8 +: 8] = i_mem_word[b*8 +: 8];
      end
    end
  end

  if (RD_REGISTERED != 0) begin : g_reg
    logic [LUT_WIDTH-1:0] r_rd_data;

    // Captures zero during a clear so no stale word survives its last edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rd_data <= '0;
      end else if (i_busy || !w_in_range) begin
        r_rd_data <= '0;
      end else begin
        r_rd_data <= w_merged;
      end
    end

    assign o_rd_data = i_busy ? '0 : r_rd_data;
  end else begin : g_comb
    logic w_unused;
    assign w_unused  = &{1'b0, clk, rst, w_merged};
    assign o_rd_data = (i_busy || !w_in_range) ? '0 : i_mem_word;
  end

endmodule : lut_ram_rd_port

// File: rtl/lut_ram_mp.sv
// Multi-read-port byte-strobed LUT RAM with a hardware clear sequencer that
// zeroes every entry after reset or on clear_req.
module lut_ram_mp
  import riscv_32i_defs_pkg::*;
#(
  parameter int LUT_WIDTH     = XLEN,
  parameter int LUT_DEPTH     = 256,
  parameter int NUM_RD_PORTS  = 2,
  parameter int RD_REGISTERED = 0,
  localparam int ADDR_W       = $clog2(LUT_DEPTH)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     clear_req,
  input  logic                                     wr_en,
  input  logic [LUT_WIDTH/8-1:0]                   wr_strb,
  input  logic [ADDR_W-1:0]                        wr_addr,
  input  logic [LUT_WIDTH-1:0]                     wr_data,
  input  logic [NUM_RD_PORTS-1:0][ADDR_W-1:0]      rd_addr,
  output logic [NUM_RD_PORTS-1:0][LUT_WIDTH-1:0]   rd_data,
  output logic                                     busy,
  output logic                                     clear_done
);

  localparam int              NUM_BYTES = LUT_WIDTH / 8;
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(LUT_DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(LUT_DEPTH);

  lut_clr_state_t       r_state, w_state_nxt;
  logic [ADDR_W-1:0]    r_clr_ptr, w_clr_ptr_nxt;
  logic                 r_clear_done, w_clear_done_nxt;
  logic [LUT_WIDTH-1:0] r_mem [LUT_DEPTH];

  logic                 w_busy;
  logic                 w_wr_commit;
  logic                 w_clr_wr;
  logic [ADDR_W-1:0]    w_clr_addr;

  assign w_busy      = (r_state == LUT_CLEAR);
  assign w_wr_commit = !w_busy && wr_en && !clear_req && !rst &&
                       ({1'b0, wr_addr} < DEPTH_EXT);
  // Held reset keeps zeroing entry 0; a clear_req edge only rewinds the pointer.
  assign w_clr_wr    = rst || (w_busy && !clear_req);
  assign w_clr_addr  = rst ? '0 : r_clr_ptr;

  // Clear sequencer next-state: reset or clear_req always restarts from 0.
  always_comb begin
    w_state_nxt      = r_state;
    w_clr_ptr_nxt    = r_clr_ptr;
    w_clear_done_nxt = 1'b0;
    if (rst || clear_req) begin
      w_state_nxt   = LUT_CLEAR;
      w_clr_ptr_nxt = '0;
    end else begin
      case (r_state)
        LUT_IDLE: begin
          w_state_nxt = LUT_IDLE;
        end
        LUT_CLEAR: begin
          if (r_clr_ptr == PTR_LAST) begin
            w_state_nxt      = LUT_IDLE;
            w_clr_ptr_nxt    = '0;
            w_clear_done_nxt = 1'b1;
          end else begin
            w_clr_ptr_nxt = r_clr_ptr + 1'b1;
          end
        end
        default: begin
          w_state_nxt = LUT_CLEAR;
        end
      endcase
    end
  end

  // Clear sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= LUT_CLEAR;
      r_clr_ptr    <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_ptr    <= w_clr_ptr_nxt;
      r_clear_done <= w_clear_done_nxt;
    end
  end

  // Storage: clear writes take priority over byte-lane user writes.
  always_ff @(posedge clk) begin
    if (w_clr_wr) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_commit) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr_strb[b]) begin
          r_mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    lut_ram_rd_port #(
      .LUT_WIDTH     (LUT_WIDTH),
      .LUT_DEPTH     (LUT_DEPTH),
      .RD_REGISTERED (RD_REGISTERED)
    ) u_rd_port (
      .clk         (clk),
      .rst         (rst),
      .i_busy      (w_busy),
      .i_rd_addr   (rd_addr[p]),
      .i_mem_word  (r_mem[rd_addr[p]]),
      .i_wr_commit (w_wr_commit),
      .i_wr_addr   (wr_addr),
      .i_wr_strb   (wr_strb),
      .i_wr_data   (wr_data),
      .o_rd_data   (rd_data[p])
    );
  end

  assign busy       = w_busy;
  assign clear_done = r_clear_done;

endmodule : lut_ram_mp

// File: tb/tb_lut_ram_mp.sv
// Bench for lut_ram_mp: a 256-entry combinational instance and a 200-entry
// registered instance share stimulus and are checked against one array model.
module tb_lut_ram_mp;

  logic             clk = 1'b0;
  logic             rst, clear_req, wr_en;
  logic [3:0]       wr_strb;
  logic [7:0]       wr_addr;
  logic [31:0]      wr_data;
  logic [1:0][7:0]  rd_addr;
  logic [1:0][31:0] rd_data0, rd_data1;
  logic             busy0, busy1, clear_done0, clear_done1;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;

  always #5 clk = ~clk;

  lut_ram_mp u_dut0 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .wr_en(wr_en),
    .wr_strb(wr_strb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data0), .busy(busy0), .clear_done(clear_done0)
  );

  lut_ram_mp #(.LUT_DEPTH(200), .RD_REGISTERED(1)) u_dut1 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .wr_en(wr_en),
    .wr_strb(wr_strb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data1), .busy(busy1), .clear_done(clear_done1)
  );

  always @(negedge clk) begin
    if (clear_done0 === 1'b1) done_cnt0++;
    if (clear_done1 === 1'b1) done_cnt1++;
  end

  // Reference model: index 0 = depth 256 combinational, 1 = depth 200 registered.
  logic [31:0] m_mem [2][256];
  int          m_left [2];
  bit          m_done [2];
  logic [31:0] m_rdreg [2][2];
  bit          m_valid = 1'b0;

  function automatic int dep_of(input int d);
    return (d == 0) ? 256 : 200;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [31:0] e, a;
    if (m_valid) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("busy%0d", d), 32'((d == 0) ? busy0 : busy1), 32'(m_left[d] > 0));
        chk($sformatf("done%0d", d), 32'((d == 0) ? clear_done0 : clear_done1), 32'(m_done[d]));
        for (int p = 0; p < 2; p++) begin
          if (m_left[d] > 0) e = 32'h0;
          else if (d == 1) e = m_rdreg[1][p];
          else e = m_mem[0][rd_addr[p]];
          a = (d == 0) ? rd_data0[p] : rd_data1[p];
          chk($sformatf("rd%0d_p%0d_a%0d", d, p, rd_addr[p]), a, e);
        end
      end
    end
  endtask

  task automatic model_update();
    int dep;
    bit was_busy, commit;
    for (int d = 0; d < 2; d++) begin
      dep      = dep_of(d);
      was_busy = (m_left[d] > 0);
      commit   = !was_busy && wr_en && !clear_req && !rst && (int'(wr_addr) < dep);
      if (commit) begin
        for (int b = 0; b < 4; b++)
          if (wr_strb[b]) m_mem[d][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
      end
      if (rst) m_mem[d][0] = 32'h0;
      else if (was_busy && !clear_req) m_mem[d][dep - m_left[d]] = 32'h0;
      for (int p = 0; p < 2; p++)
        m_rdreg[d][p] = (rst || was_busy || int'(rd_addr[p]) >= dep) ? 32'h0 : m_mem[d][rd_addr[p]];
      m_done[d] = 1'b0;
      if (rst || clear_req) begin
        m_left[d] = dep;
      end else if (was_busy) begin
        m_left[d]--;
        m_done[d] = (m_left[d] == 0);
      end
    end
    if (rst) m_valid = 1'b1;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy0 || busy1) && n < 400) begin
      cycle();
      n++;
    end
    chk(nm, 32'(busy0 | busy1), 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  strb;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [7:0]  ra0, ra1;
    logic [31:0] e0, e1;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, n0, n1, d0, d1;
    rst = 1'b1; clear_req = 1'b0; wr_en = 1'b0; wr_strb = 4'h0;
    wr_addr = 8'h0; wr_data = 32'h0; rd_addr = '0;

    // Reset held 3 cycles, then count clear length on both instances.
    repeat (3) cycle();
    chk("rst_busy0", 32'(busy0), 32'h1);
    chk("rst_busy1", 32'(busy1), 32'h1);
    chk("rst_done0", 32'(clear_done0), 32'h0);
    chk("rst_rd1", rd_data1[0], 32'h0);
    rst = 1'b0;
    d0 = done_cnt0; d1 = done_cnt1;
    n = 0; n0 = 0; n1 = 0;
    while ((busy0 || busy1) && n < 400) begin
      if (busy0) n0++;
      if (busy1) n1++;
      cycle();
      n++;
    end
    chk("clr_len0", 32'(n0), 32'd256);
    chk("clr_len1", 32'(n1), 32'd200);
    chk("clr_done_now0", 32'(clear_done0), 32'h1);
    cycle();
    chk("clr_pulses0", 32'(done_cnt0 - d0), 32'h1);
    chk("clr_pulses1", 32'(done_cnt1 - d1), 32'h1);

    for (int a = 0; a < 256; a++) begin
      rd_addr[0] = 8'(a); rd_addr[1] = 8'(255 - a);
      #2;
      chk("zero_after_clr", rd_data0[0] | rd_data0[1], 32'h0);
      cycle();
    end

    // Byte strobes and multi-port reads, checked on the combinational instance.
    tbl[0] = '{1'b1, 4'hF, 8'd10, 32'hDEADBEEF, 8'd10, 8'd3,  32'h0,        32'h0};
    tbl[1] = '{1'b1, 4'h5, 8'd10, 32'h11223344, 8'd10, 8'd10, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 4'hF, 8'd3,  32'h5,        8'd10, 8'd3,  32'hDE22BE44, 32'h0};
    tbl[3] = '{1'b1, 4'hF, 8'd7,  32'h9,        8'd3,  8'd7,  32'h5,        32'h0};
    tbl[4] = '{1'b0, 4'h0, 8'd0,  32'h0,        8'd3,  8'd7,  32'h5,        32'h9};
    tbl[5] = '{1'b0, 4'h0, 8'd0,  32'h0,        8'd10, 8'd10, 32'hDE22BE44, 32'hDE22BE44};
    for (int i = 0; i < 6; i++) begin
      wr_en = tbl[i].we; wr_strb = tbl[i].strb; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_addr[0] = tbl[i].ra0; rd_addr[1] = tbl[i].ra1;
      #2;
      chk($sformatf("tbl%0d_p0", i), rd_data0[0], tbl[i].e0);
      chk($sformatf("tbl%0d_p1", i), rd_data0[1], tbl[i].e1);
      cycle();
    end

    // Registered write-first forwarding.
    wr_en = 1'b1; wr_strb = 4'hF; wr_addr = 8'd20; wr_data = 32'hAAAAAAAA;
    cycle();
    wr_strb = 4'b0001; wr_data = 32'h000000FF; rd_addr[0] = 8'd20;
    cycle();
    wr_en = 1'b0;
    chk("wfirst_reg", rd_data1[0], 32'hAAAAAAFF);
    chk("wfirst_comb", rd_data0[0], 32'hAAAAAAFF);

    // Out-of-range write/read on the 200-entry instance.
    wr_en = 1'b1; wr_strb = 4'hF; wr_addr = 8'd250; wr_data = 32'h12345678;
    rd_addr[0] = 8'd250; rd_addr[1] = 8'd250;
    cycle();
    wr_en = 1'b0;
    chk("range_d1", rd_data1[0], 32'h0);
    chk("range_d0", rd_data0[1], 32'h12345678);

    // clear_req beats a same-cycle write; writes while busy are dropped.
    clear_req = 1'b1; wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'h7;
    cycle();
    clear_req = 1'b0; wr_addr = 8'd0; wr_data = 32'h3;
    cycle();
    wr_en = 1'b0;
    wait_idle("collide_idle");
    rd_addr[0] = 8'd5; rd_addr[1] = 8'd0;
    #2;
    chk("collide_a5", rd_data0[0], 32'h0);
    chk("busy_wr_a0", rd_data0[1], 32'h0);
    cycle();
    chk("busy_wr_a0_reg", rd_data1[1], 32'h0);

    // Restart at cycle 100 of a clear.
    d0 = done_cnt0;
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    repeat (99) cycle();
    chk("restart_no_done", 32'(done_cnt0 - d0), 32'h0);
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    n = 0;
    while (busy0 && n < 400) begin
      cycle();
      n++;
    end
    chk("restart_len", 32'(n), 32'd256);
    cycle();
    chk("restart_pulses", 32'(done_cnt0 - d0), 32'h1);

    // Randomized traffic against the model, with rare clear requests.
    for (int i = 0; i < 1500; i++) begin
      wr_en     = 1'($urandom);
      wr_strb   = 4'($urandom);
      wr_addr   = 1'($urandom) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      wr_data   = 32'($urandom);
      rd_addr[0] = 1'($urandom) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      rd_addr[1] = 1'($urandom) ? wr_addr : 8'($urandom);
      clear_req = ($urandom_range(0, 299) == 0);
      cycle();
    end
    clear_req = 1'b0; wr_en = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule : tb_lut_ram_mp
